cic_integ_decim: RTL
====================

// Module: cic_integ_decim
// PURPOSE
//  Front half of the CIC decimator: N cascaded integrators at the input rate, then a 1-in-R
//  downsampler. Each dout_valid pulse is the clock enable for the comb chain downstream.
//  The comb stages reuse dout unchanged as their input, so this block owns all bit growth.
// PARAMETERS
//  DW  16  input sample width, signed two's complement
//  N   3   number of integrator stages (>=1)
//  R   4   decimation ratio, compile-time default (>=1)
//  M   1   comb differential delay; used only to size OW
//  OW  22  output/accumulator width; must be >= DW + N*clog2(R*M)
//  RW  8   rate port width (CIC_RUNTIME_RATE_EN only)
// PORTS
//  clk        in   1   sole clock, rising edge
//  reset      in   1   synchronous, active-high reset
//  din_valid  in   1   input sample strobe (input-rate enable)
//  din        in   DW  signed input sample
//  clear      in   1   synchronous flush: integrators and phase counter to 0
//  rate       in   RW  runtime decimation ratio (present only with CIC_RUNTIME_RATE_EN)
//  dout_valid out  1   one-cycle pulse per R accepted inputs; drives comb ce
//  dout       out  OW  signed decimated integrator output
// BEHAVIOUR
//  - Reset (clk edge with reset=1): all integrators, phase counter, dout and dout_valid = 0.
//    Reset takes effect mid-frame; the partial frame is discarded.
//  - clear=1 does the same as reset. clear has priority over din_valid in the same cycle.
//  - On din_valid=1 (no reset, no clear):
//      int[0] <= int[0] + sext(din)
//      int[k] <= int[k] + int[k-1] (pre-edge value), k=1..N-1
//  - Arithmetic is OW-bit modular. Wrap-around is intentional and is never flagged or
//    saturated. The comb chain cancels it.
//  - Phase counter cnt runs 0..R-1 and advances only on din_valid.
//    At cnt==R-1 with din_valid: cnt <= 0, dout <= int_next[N-1], dout_valid <= 1.
//  - dout_valid is 1 only in the cycle after the R-th accepted sample, otherwise 0.
//    dout holds its value between pulses.
//  - Latency: an input first affects int[N-1] after N accepted samples. dout is registered
//    1 clock after the strobe that completes a frame.
//  - din_valid=0 freezes all state. Gaps of any length are allowed.
//  - Back-to-back din_valid is allowed. With R=1 every accepted sample produces a pulse.
// CONFIGURATION
//  - CIC_RUNTIME_RATE_EN defined: the rate port exists and sets the effective R.
//    - rate is sampled into r_act only when cnt wraps to 0, and at reset or clear.
//    - rate=0 and rate=1 both mean R=1.
//    - A rate change mid-frame never shortens or lengthens the current frame.
//    - OW must be sized for the maximum rate used.
//  - CIC_RUNTIME_RATE_EN undefined: no rate port; R is the fixed parameter.
//    cnt width is clog2(R), or 1 bit when R=1.
// STRUCTURE
//  - Shared package cic_pkg: clog2 function, cic_out_width(DW,N,R,M) = DW+N*clog2(R*M).
//    The comb chain uses the same width constants.
//  - Sub-module cic_integrator: one OW-bit enabled accumulator with sync reset/clear,
//    instantiated N times in a generate loop.
//  - Top level: sign extension, phase counter, optional rate latch, output register.
// TESTING  (DW=16, N=3, R=4, OW=22 unless noted)
//  - Impulse: din=1 on the first strobe, then 0 on continuous strobes.
//    -> dout 3, 21, 55, 105 on successive pulses; a pulse every 4th strobe.
//  - Strobe gaps: same impulse with din_valid toggling 1,0,1,0.
//    -> identical dout sequence; pulses spaced 8 clocks.
//  - Wrap-around: din=32767 on continuous strobes for 200 samples.
//    -> dout matches the mod-2^22 reference model bit-exactly; no saturation.
//  - Reset mid-frame after 2 strobes, then an impulse.
//    -> dout=0 and dout_valid=0 the cycle after reset; next pulse after exactly 4 strobes.
//  - clear and din_valid asserted together.
//    -> clear wins; state is 0 and the sample is dropped.
//  - CIC_RUNTIME_RATE_EN, R=4: change rate to 2 during cnt=1.
//    -> current frame still spans 4 strobes; later frames span 2. rate=0 gives a pulse
//       per strobe.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared CIC sizing helpers; the comb chain uses the same width constants.
package cic_pkg;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((longint'(1) << r) < longint'(v)) r++;
      return r;
   endfunction

   // Worst-case register growth across N stages at ratio R and differential delay M.
   function automatic int unsigned cic_out_width(input int unsigned dw, input int unsigned n,
                                                 input int unsigned r, input int unsigned m);
      return dw + n * clog2(r * m);
   endfunction

endpackage

// File: rtl/cic_integrator.sv
// One CIC integrator stage: OW-bit modular accumulator with enable and sync flush.
module cic_integrator #(
   parameter int unsigned OW = 22
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          en,
   input  logic [OW-1:0] x,
   output logic [OW-1:0] acc
);

   // Wrap-around is intended; the downstream comb chain cancels it.
   always_ff @(posedge clk) begin
      if (reset || clear) acc <= '0;
      else if (en)        acc <= acc + x;
   end

endmodule

// File: rtl/cic_integ_decim.sv
// CIC decimator front half: N integrators at input rate followed by a 1-in-R downsampler.
// Optional build macro CIC_RUNTIME_RATE_EN adds the rate port for a runtime decimation ratio.
module cic_integ_decim
   import cic_pkg::*;
#(
   parameter int unsigned DW = 16,
   parameter int unsigned N  = 3,
   parameter int unsigned R  = 4,
   parameter int unsigned M  = 1,
   parameter int unsigned OW = cic_out_width(DW, N, R, M)
`ifdef CIC_RUNTIME_RATE_EN
   ,parameter int unsigned RW = 8
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 din_valid,
   input  logic signed [DW-1:0] din,
   input  logic                 clear,
`ifdef CIC_RUNTIME_RATE_EN
   input  logic [RW-1:0]        rate,
`endif
   output logic                 dout_valid,
   output logic signed [OW-1:0] dout
);

`ifdef CIC_RUNTIME_RATE_EN
   localparam int unsigned CW = RW;
`else
   localparam int unsigned CW = (R > 1) ? clog2(R) : 1;
`endif

   logic [OW-1:0] stage_in [N];
   logic [OW-1:0] acc      [N];
   logic [OW-1:0] last_next_c;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_lim;
   logic          wrap_c;

   assign stage_in[0] = OW'(din);

   for (genvar k = 0; k < N; k++) begin : g_stage
      if (k > 0) begin : g_link
         assign stage_in[k] = acc[k-1];
      end
      cic_integrator #(.OW(OW)) u_integ (
         .clk   (clk),
         .reset (reset),
         .clear (clear),
         .en    (din_valid),
         .x     (stage_in[k]),
         .acc   (acc[k])
      );
   end

   // Value the last integrator takes at this edge, captured directly into dout on a wrap.
   assign last_next_c = acc[N-1] + stage_in[N-1];
   assign wrap_c      = din_valid && (cnt == cnt_lim);

`ifdef CIC_RUNTIME_RATE_EN
   logic [RW-1:0] lim_c;
   logic [RW-1:0] r_lim;

   // rate 0 and 1 both mean one sample per frame; latched only at frame boundaries.
   assign lim_c = (rate <= RW'(1)) ? '0 : rate - RW'(1);

   always_ff @(posedge clk) begin
      if (reset || clear || wrap_c) r_lim <= lim_c;
   end

   assign cnt_lim = r_lim;
`else
   assign cnt_lim = CW'(R - 1);
`endif

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt        <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         if (wrap_c) begin
            cnt        <= '0;
            dout       <= last_next_c;
            dout_valid <= 1'b1;
         end else if (din_valid) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule
